// File: rtl/mac_lut_lookup_arbiter.sv
// Round-robin arbiter that shares the MAC CAM LUT lookup/learn port between NUM_REQ
// header parsers. It allows one outstanding LUT transaction and a watchdog fallback.
// Optional hit/miss/timeout counters are built when MAC_LUT_ARB_STATS_EN is defined.
module mac_lut_lookup_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int REQ_IDX_BITS      = 2,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_IQ_BITS       = 3,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [48*NUM_REQ-1:0]          req_dst_mac,
  input  logic [48*NUM_REQ-1:0]          req_src_mac,
  input  logic [NUM_IQ_BITS*NUM_REQ-1:0] req_src_port,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_OUTPUT_QUEUES-1:0]   rsp_dst_ports,
  output logic                           rsp_hit,
  output logic                           rsp_timeout,
  output logic [47:0]                    lut_dst_mac,
  output logic [47:0]                    lut_src_mac,
  output logic [NUM_IQ_BITS-1:0]         lut_src_port,
  output logic                           lut_lookup_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0]   lut_dst_ports,
  input  logic                           lut_lookup_ack,
  input  logic                           lut_hit,
  input  logic                           lut_miss,
  output logic [31:0]                    stat_hits,
  output logic [31:0]                    stat_misses,
  output logic [31:0]                    stat_timeouts
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW = REQ_IDX_BITS + 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

  state_t                         state_q, state_d;
  logic [REQ_IDX_BITS-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]                  timer_q, timer_d;
  logic [47:0]                    dmac_q, dmac_d, smac_q, smac_d;
  logic [NUM_IQ_BITS-1:0]         sport_q, sport_d;
  logic                           lreq_q, lreq_d;
  logic [NUM_REQ-1:0]             ack_q, ack_d;
  logic [NUM_OUTPUT_QUEUES-1:0]   rports_q, rports_d;
  logic                           rhit_q, rhit_d, rto_q, rto_d;

  logic                           gnt_found;
  logic [REQ_IDX_BITS-1:0]        gnt_idx;
  logic [CW-1:0]                  cand;

  // Search starts one past the last grant so every waiting requester is reached
  // within NUM_REQ-1 other grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!gnt_found && req_valid[cand[REQ_IDX_BITS-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[REQ_IDX_BITS-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    dmac_d   = dmac_q;
    smac_d   = smac_q;
    sport_d  = sport_q;
    lreq_d   = lreq_q;
    ack_d    = '0;
    rports_d = rports_q;
    rhit_d   = rhit_q;
    rto_d    = rto_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = WAIT_ACK;
          ptr_d   = gnt_idx;
          timer_d = '0;
          dmac_d  = req_dst_mac[48*gnt_idx +: 48];
          smac_d  = req_src_mac[48*gnt_idx +: 48];
          sport_d = req_src_port[NUM_IQ_BITS*gnt_idx +: NUM_IQ_BITS];
          lreq_d  = 1'b1;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        // An ack arriving on the expiry cycle still counts as a real answer.
        if (lut_lookup_ack) begin
          ack_d    = NUM_REQ'(1) << ptr_q;
          rports_d = lut_dst_ports;
          rhit_d   = lut_hit & ~lut_miss;
          rto_d    = 1'b0;
          lreq_d   = 1'b0;
          state_d  = RELEASE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          ack_d    = NUM_REQ'(1) << ptr_q;
          rports_d = DEFAULT_MISS_OUTPUT_PORTS & ~(NUM_OUTPUT_QUEUES'(1) << sport_q);
          rhit_d   = 1'b0;
          rto_d    = 1'b1;
          lreq_d   = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        // A late ack from an aborted lookup drains here before the next grant.
        if (!lut_lookup_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= REQ_IDX_BITS'(NUM_REQ - 1);
      timer_q  <= '0;
      dmac_q   <= '0;
      smac_q   <= '0;
      sport_q  <= '0;
      lreq_q   <= 1'b0;
      ack_q    <= '0;
      rports_q <= '0;
      rhit_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      dmac_q   <= dmac_d;
      smac_q   <= smac_d;
      sport_q  <= sport_d;
      lreq_q   <= lreq_d;
      ack_q    <= ack_d;
      rports_q <= rports_d;
      rhit_q   <= rhit_d;
      rto_q    <= rto_d;
    end
  end

  assign req_ack        = ack_q;
  assign rsp_dst_ports  = rports_q;
  assign rsp_hit        = rhit_q;
  assign rsp_timeout    = rto_q;
  assign lut_dst_mac    = dmac_q;
  assign lut_src_mac    = smac_q;
  assign lut_src_port   = sport_q;
  assign lut_lookup_req = lreq_q;

`ifdef MAC_LUT_ARB_STATS_EN
  logic [31:0] hits_q, misses_q, tos_q;

  // Counted on the same edge that raises req_ack so the totals line up with the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      tos_q    <= '0;
    end else if (|ack_d) begin
      if (rto_d)       tos_q    <= tos_q + 32'd1;
      else if (rhit_d) hits_q   <= hits_q + 32'd1;
      else             misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;
  assign stat_timeouts = tos_q;
`else
  assign stat_hits     = '0;
  assign stat_misses   = '0;
  assign stat_timeouts = '0;
`endif

endmodule
